// File: rtl/multi_timer_pkg.sv
// Shared constants and helpers for the multi-channel millisecond timer.
// Optional build macro: MULTI_TIMER_STICKY_EN (sticky expiry flags, see multi_timer).
package multi_timer_pkg;

  localparam int CLKS_PER_MS_DEFAULT = 50000;
  localparam int MAX_MS_DEFAULT      = 1000;

  // Clamp a requested load value to the largest representable period.
  function automatic int sat_load(input int value, input int max_ms);
    return (value > max_ms) ? max_ms : value;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running clock-to-millisecond prescaler; ms_tick is high during the
// single cycle where the counter sits at its terminal value.
module ms_tick_gen
  import multi_timer_pkg::*;
#(
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  output logic ms_tick
);

  localparam int CW = $clog2(CLKS_PER_MS);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_MS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign ms_tick = (count == LAST);

endmodule

// File: rtl/multi_timer.sv
// NUM_CH independent ms countdown channels sharing one prescaler.
// Build macro MULTI_TIMER_STICKY_EN turns expired into sticky flags with clear_expired.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int MAX_MS      = MAX_MS_DEFAULT,
  parameter int CLKS_PER_MS = CLKS_PER_MS_DEFAULT
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_CH-1:0]                     load,
  input  logic [NUM_CH*$clog2(MAX_MS+1)-1:0]    start_value,
  input  logic [NUM_CH-1:0]                     enable,
  input  logic [NUM_CH-1:0]                     periodic,
`ifdef MULTI_TIMER_STICKY_EN
  input  logic [NUM_CH-1:0]                     clear_expired,
`endif
  output logic [NUM_CH*$clog2(MAX_MS+1)-1:0]    timer_value,
  output logic [NUM_CH-1:0]                     expired,
  output logic [NUM_CH-1:0]                     running
);

  localparam int W = $clog2(MAX_MS + 1);

  logic ms_tick;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .ms_tick(ms_tick)
  );

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [W-1:0] value;
    logic [W-1:0] reload;
    logic [W-1:0] load_value;
    logic         flag;
    logic         run;

    assign load_value = W'(sat_load(32'(start_value[i*W +: W]), MAX_MS));

    // Priority: load, then terminal tick, then plain decrement / hold.
    always_ff @(posedge clk) begin
      if (reset) begin
        value  <= '0;
        reload <= '0;
        flag   <= 1'b0;
        run    <= 1'b0;
      end else begin
        run <= enable[i] && (value != '0);
        if (load[i]) begin
          value  <= load_value;
          reload <= load_value;
          flag   <= 1'b0;
        end else if (ms_tick && enable[i] && value == W'(1)) begin
          value <= periodic[i] ? reload : '0;
          flag  <= 1'b1;
        end else begin
          if (ms_tick && enable[i] && value != '0) begin
            value <= value - W'(1);
          end
`ifdef MULTI_TIMER_STICKY_EN
          if (clear_expired[i]) begin
            flag <= 1'b0;
          end
`else
          flag <= 1'b0;
`endif
        end
      end
    end

    assign timer_value[i*W +: W] = value;
    assign expired[i]            = flag;
    assign running[i]            = run;
  end

endmodule
